ir_key_fifo: RTL and testbench

- Consumer stage directly downstream of the IR NEC frame decoder.
- Takes each 32-bit frame the decoder presents on its ready/command/ack handshake and checks the NEC inverse bytes.
- Valid key codes go into a small first-word-fall-through FIFO, read by the CPU/peripheral side.
- Keeps saturating error and overflow statistics.

---
 rtl/ir_key_fifo.sv | 92 +++++++++
 tb/tb_ir_key_fifo.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/ir_key_fifo.sv
// ir_key_fifo: NEC frame inverse check feeding a first-word-fall-through key FIFO
// with saturating error/overflow statistics.
module ir_key_fifo #(
   parameter int DEPTH       = 8,
   parameter int AW          = 3,
   parameter int STRICT_ADDR = 0,
   parameter int ERR_W       = 8
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_cmd_ready,
   input  logic [31:0]       i_cmd_data,
   output logic              o_cmd_ack,
   input  logic              i_pop,
   output logic              o_key_valid,
   output logic [7:0]        o_key_addr,
   output logic [7:0]        o_key_cmd,
   output logic [AW:0]       o_fifo_count,
   output logic [ERR_W-1:0]  o_err_count,
   output logic [ERR_W-1:0]  o_ovf_count,
   input  logic              i_clr_stats
);
   typedef enum logic [1:0] {IDLE, CHECK, ACK} state_t;
   state_t           r_state, w_next;
   logic [31:0]      r_frame;
   logic             r_ack;
   logic [15:0]      r_mem [DEPTH];
   logic [AW-1:0]    r_wp, r_rp;
   logic [AW:0]      r_cnt;
   logic [ERR_W-1:0] r_err, r_ovf;
   logic             w_full, w_empty, w_valid, w_chk, w_pop, w_push, w_err_inc, w_ovf_inc;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = i_cmd_ready ? CHECK : IDLE;
         CHECK:   w_next = ACK;
         default: w_next = i_cmd_ready ? ACK : IDLE;
      endcase
   end

   assign w_full    = (r_cnt == (AW+1)'(DEPTH));
   assign w_empty   = (r_cnt == '0);
   assign w_chk     = (r_state == CHECK);
   assign w_valid   = (r_frame[31:24] == ~r_frame[23:16]) &&
                      (STRICT_ADDR == 0 || r_frame[15:8] == ~r_frame[7:0]);
   assign w_pop     = i_pop && !w_empty;
   // A same-cycle pop frees the slot, so a full FIFO can still accept the frame.
   assign w_push    = w_chk && w_valid && (!w_full || w_pop);
   assign w_err_inc = w_chk && !w_valid;
   assign w_ovf_inc = w_chk && w_valid && w_full && !w_pop;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
         r_ack   <= 1'b0;
         r_frame <= '0;
         r_wp    <= '0;
         r_rp    <= '0;
         r_cnt   <= '0;
         r_err   <= '0;
         r_ovf   <= '0;
      end else begin
         r_state <= w_next;
         r_ack   <= (w_next == ACK);
         if (r_state == IDLE && i_cmd_ready) r_frame <= i_cmd_data;
         if (w_push) r_wp <= r_wp + 1'b1;
         if (w_pop) r_rp <= r_rp + 1'b1;
         if (w_push && !w_pop) r_cnt <= r_cnt + 1'b1;
         else if (w_pop && !w_push) r_cnt <= r_cnt - 1'b1;
         if (i_clr_stats) begin
            r_err <= '0;
            r_ovf <= '0;
         end else begin
            if (w_err_inc && r_err != '1) r_err <= r_err + 1'b1;
            if (w_ovf_inc && r_ovf != '1) r_ovf <= r_ovf + 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wp] <= {r_frame[7:0], r_frame[23:16]};
   end

   assign o_cmd_ack    = r_ack;
   assign o_key_valid  = !w_empty;
   assign o_key_addr   = w_empty ? 8'h00 : r_mem[r_rp][15:8];
   assign o_key_cmd    = w_empty ? 8'h00 : r_mem[r_rp][7:0];
   assign o_fifo_count = r_cnt;
   assign o_err_count  = r_err;
   assign o_ovf_count  = r_ovf;
endmodule

// File: tb/tb_ir_key_fifo.sv
// tb_ir_key_fifo: directed frames; expected keys queued by stimulus, checked by a pop monitor.
module tb_ir_key_fifo;
   logic        clk = 0, rst_n = 0, cmd_ready = 0, pop = 0, clr = 0;
   logic [31:0] cmd_data = '0;
   logic        ack0, kv0, ack1, kv1;
   logic [7:0]  ka0, kc0, ka1, kc1, err0, ovf0, err1, ovf1;
   logic [3:0]  cnt0, cnt1;
   int          n_cmp = 0, n_bad = 0;
   logic [15:0] exp_q [$];

   always #5 clk = ~clk;

   ir_key_fifo #(.DEPTH(8), .AW(3), .STRICT_ADDR(0), .ERR_W(8)) u0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_cmd_ready(cmd_ready), .i_cmd_data(cmd_data),
      .o_cmd_ack(ack0), .i_pop(pop), .o_key_valid(kv0), .o_key_addr(ka0), .o_key_cmd(kc0),
      .o_fifo_count(cnt0), .o_err_count(err0), .o_ovf_count(ovf0), .i_clr_stats(clr));

   ir_key_fifo #(.DEPTH(8), .AW(3), .STRICT_ADDR(1), .ERR_W(8)) u1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_cmd_ready(cmd_ready), .i_cmd_data(cmd_data),
      .o_cmd_ack(ack1), .i_pop(pop), .o_key_valid(kv1), .o_key_addr(ka1), .o_key_cmd(kc1),
      .o_fifo_count(cnt1), .o_err_count(err1), .o_ovf_count(ovf1), .i_clr_stats(clr));

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && pop && kv0) begin
         if (exp_q.size() == 0) chk("pop_unexpected", 1, 0);
         else chk("pop_key", {ka0, kc0}, exp_q.pop_front());
      end
   end

   task automatic tick;
      @(posedge clk); #1;
   endtask

   function automatic logic [31:0] frm(input logic [7:0] c);
      return {~c, c, 8'hFF, 8'h00};
   endfunction

   task automatic send(input logic [31:0] d);
      int k = 0;
      cmd_data = d; cmd_ready = 1;
      do begin tick; k++; end while (!ack0 && k < 10);
      if (!ack0) chk("ack_timeout", 0, 1);
      cmd_ready = 0;
      tick;
      chk("ack_fall", ack0, 0);
   endtask

   task automatic pop_n(input int n);
      pop = 1;
      repeat (n) tick;
      pop = 0;
   endtask

   initial begin
      int bad, acks;
      repeat (3) tick;
      chk("rst_ack", ack0, 0); chk("rst_valid", kv0, 0); chk("rst_key", {ka0, kc0}, 0);
      chk("rst_cnt", cnt0, 0); chk("rst_err", err0, 0); chk("rst_ovf", ovf0, 0);
      rst_n = 1;
      tick;
      // valid frame with latency
      exp_q.push_back(16'h0045);
      cmd_data = 32'hBA45FF00; cmd_ready = 1;
      tick; chk("lat_ack_e0", ack0, 0); chk("lat_valid_e0", kv0, 0);
      tick; chk("lat_ack_e1", ack0, 1); chk("lat_valid_e1", kv0, 1);
      chk("t1_addr", ka0, 8'h00); chk("t1_cmd", kc0, 8'h45); chk("t1_cnt", cnt0, 1); chk("t1_err", err0, 0);
      cmd_ready = 0;
      tick; chk("t1_ack_fall", ack0, 0);
      pop_n(1);
      chk("t1_pop_valid", kv0, 0); chk("t1_pop_cnt", cnt0, 0);
      pop_n(1);
      chk("empty_pop_cnt", cnt0, 0); chk("empty_pop_valid", kv0, 0);
      // bad command inverse
      send(32'hBA44FF00);
      chk("t2_err", err0, 1); chk("t2_cnt", cnt0, 0); chk("t2_err_strict", err1, 1);
      // address inverse only matters when strict
      exp_q.push_back(16'h0045);
      send(32'hBA45FE00);
      chk("t3_cnt", cnt0, 1); chk("t3_err", err0, 1); chk("t3_err_strict", err1, 2);
      chk("t3_cnt_strict", cnt1, 0); chk("t3_cmd", kc0, 8'h45);
      pop_n(1);
      // overflow and wrap
      for (int c = 1; c <= 9; c++) begin
         if (c <= 8) exp_q.push_back({8'h00, 8'(c)});
         send(frm(8'(c)));
      end
      chk("ovf_cnt", cnt0, 8); chk("ovf_count", ovf0, 1); chk("ovf_head", kc0, 8'h01);
      pop_n(8);
      chk("drain_cnt", cnt0, 0);
      for (int c = 10; c <= 12; c++) begin
         exp_q.push_back({8'h00, 8'(c)});
         send(frm(8'(c)));
      end
      chk("wrap_cnt", cnt0, 3);
      pop_n(3);
      chk("wrap_drain", cnt0, 0);
      // push and pop together while full
      for (int c = 8'h30; c <= 8'h37; c++) begin
         exp_q.push_back({8'h00, 8'(c)});
         send(frm(8'(c)));
      end
      exp_q.push_back(16'h0038);
      cmd_data = frm(8'h38); cmd_ready = 1;
      tick;
      pop = 1;
      tick;
      pop = 0;
      chk("full_pp_cnt", cnt0, 8); chk("full_pp_ovf", ovf0, 1); chk("full_pp_head", kc0, 8'h31);
      cmd_ready = 0;
      tick;
      pop_n(8);
      chk("full_pp_drain", cnt0, 0);
      // handshake hold
      exp_q.push_back(16'h0020);
      cmd_data = frm(8'h20); cmd_ready = 1;
      bad = 0; acks = 0;
      for (int i = 0; i < 200; i++) begin
         tick;
         if (i >= 1 && !ack0) bad++;
         if (ack0) acks++;
      end
      chk("hold_ack_low", bad, 0); chk("hold_ack_cycles", acks, 199); chk("hold_cnt", cnt0, 1);
      cmd_ready = 0;
      tick; chk("hold_ack_fall", ack0, 0);
      exp_q.push_back(16'h0021);
      send(frm(8'h21));
      chk("hold_next_cnt", cnt0, 2);
      pop_n(2);
      // error counter saturation
      for (int i = 0; i < 260; i++) send(32'hBA44FF00);
      chk("sat_err", err0, 8'hFF);
      // clear in the same cycle as an error
      cmd_data = 32'hBA44FF00; cmd_ready = 1;
      tick;
      clr = 1;
      tick;
      clr = 0;
      chk("clr_err", err0, 0); chk("clr_ovf", ovf0, 0); chk("clr_err_strict", err1, 0);
      cmd_ready = 0;
      tick;
      // reset during ACK
      send(32'hBA44FF00);
      cmd_data = frm(8'h40); cmd_ready = 1;
      tick; tick;
      chk("pre_rst_ack", ack0, 1); chk("pre_rst_cnt", cnt0, 1);
      #2 rst_n = 0;
      #1;
      chk("rst_ack_async", ack0, 0); chk("rst_cnt_async", cnt0, 0);
      chk("rst_valid_async", kv0, 0); chk("rst_err_async", err0, 0);
      cmd_ready = 0;
      tick;
      rst_n = 1;
      tick;
      exp_q.push_back(16'h0041);
      send(frm(8'h41));
      chk("post_rst_cnt", cnt0, 1); chk("post_rst_cmd", kc0, 8'h41);
      pop_n(1);
      chk("queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected done");
      $fatal(1);
   end
endmodule
